// File: rtl/hx8352_window_fill_sequencer.sv
// Writes the HX8352 window registers and GRAM index, then streams one colour word per pixel.
// One registered step pulse per word, then at least STEP_GAP idle cycles, stretched while bus_busy is high.
module hx8352_window_fill_sequencer #(
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int H_RES    = 240,
    parameter int V_RES    = 400,
    parameter int STEP_GAP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic [15:0]    color,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [15:0]    bus_data,
    output logic           bus_cmd,
    output logic           bus_step,
    input  logic           bus_busy
);

    localparam int GW = $clog2(STEP_GAP);
    localparam logic [GW-1:0]  GAP_LAST = GW'(STEP_GAP - 1);
    localparam logic [X_W-1:0] X_MAX    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {PH_REG, PH_GRAM, PH_PIXEL} phase_t;

    state_t         state, state_n;
    phase_t         phase, phase_n;
    logic [3:0]     reg_idx, reg_idx_n;
    logic [X_W-1:0] col, col_n, lx0, lx1;
    logic [Y_W-1:0] row, row_n, ly0, ly1;
    logic [15:0]    lcolor;
    logic [GW-1:0]  gap_cnt, gap_n;
    logic           busy_n, done_n, error_n, step_n, cmd_n, load;
    logic [15:0]    data_n, coord;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        reg_idx_n = reg_idx;
        col_n     = col;
        row_n     = row;
        gap_n     = gap_cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = 1'b0;
        step_n    = 1'b0;
        cmd_n     = bus_cmd;
        data_n    = bus_data;
        load      = 1'b0;
        coord     = 16'h0000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (x1 < x0 || y1 < y0 || x1 > X_MAX || y1 > Y_MAX) begin
                        error_n = 1'b1;
                    end else begin
                        state_n   = S_ISSUE;
                        busy_n    = 1'b1;
                        phase_n   = PH_REG;
                        reg_idx_n = 4'd0;
                        col_n     = '0;
                        row_n     = '0;
                        load      = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
                gap_n   = '0;
            end
            S_WAIT: begin
                if (gap_cnt != GAP_LAST) begin
                    gap_n = gap_cnt + GW'(1);
                end else if (!bus_busy) begin
                    if (phase == PH_PIXEL && col == lx1 && row == ly1) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = S_ISSUE;
                        load    = 1'b1;
                        case (phase)
                            PH_REG: begin
                                if (reg_idx == 4'd15) phase_n = PH_GRAM;
                                else reg_idx_n = reg_idx + 4'd1;
                            end
                            PH_GRAM: begin
                                phase_n = PH_PIXEL;
                                col_n   = lx0;
                                row_n   = ly0;
                            end
                            default: begin
                                if (col == lx1) begin
                                    col_n = lx0;
                                    row_n = row + Y_W'(1);
                                end else begin
                                    col_n = col + X_W'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cmd_n   = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Even register slots are indices 0x02..0x09, odd slots carry the coordinate byte.
        if (load) begin
            step_n = 1'b1;
            case (phase_n)
                PH_REG: begin
                    if (!reg_idx_n[0]) begin
                        data_n = 16'(reg_idx_n[3:1]) + 16'h0002;
                        cmd_n  = 1'b0;
                    end else begin
                        case (reg_idx_n[3:2])
                            2'd0:    coord = 16'(lx0);
                            2'd1:    coord = 16'(lx1);
                            2'd2:    coord = 16'(ly0);
                            default: coord = 16'(ly1);
                        endcase
                        data_n = reg_idx_n[1] ? {8'h00, coord[7:0]} : {8'h00, coord[15:8]};
                        cmd_n  = 1'b1;
                    end
                end
                PH_GRAM: begin
                    data_n = 16'h0022;
                    cmd_n  = 1'b0;
                end
                default: begin
                    data_n = lcolor;
                    cmd_n  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            phase    <= PH_REG;
            reg_idx  <= 4'd0;
            col      <= '0;
            row      <= '0;
            gap_cnt  <= '0;
            lx0      <= '0;
            lx1      <= '0;
            ly0      <= '0;
            ly1      <= '0;
            lcolor   <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            bus_step <= 1'b0;
            bus_cmd  <= 1'b1;
            bus_data <= 16'h0000;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            reg_idx  <= reg_idx_n;
            col      <= col_n;
            row      <= row_n;
            gap_cnt  <= gap_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
            bus_step <= step_n;
            bus_cmd  <= cmd_n;
            bus_data <= data_n;
            if (state == S_IDLE && start) begin
                lx0    <= x0;
                lx1    <= x1;
                ly0    <= y0;
                ly1    <= y1;
                lcolor <= color;
            end
        end
    end

endmodule

// File: doc/hx8352_window_fill_sequencer.md
Name: hx8352_window_fill_sequencer

Overview:
Upstream stage of the HX8352 bus controller. The block takes a rectangular window and a 16-bit colour. It writes the eight HX8352 window registers, issues the GRAM-write index, and streams one colour word per pixel. Every word goes out on the bus controller's input side as a data/command word plus a one-cycle transfer_step pulse, with enforced inter-word spacing.

Parameters:
X_W, 9, width of x coordinates
Y_W, 9, width of y coordinates
H_RES, 240, panel columns; valid x is 0..H_RES-1
V_RES, 400, panel rows; valid y is 0..V_RES-1
STEP_GAP, 4, minimum idle cycles after each step pulse before the next pulse (must be >=3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
x0  in  X_W  window column start
x1  in  X_W  window column end (inclusive)
y0  in  Y_W  window row start
y1  in  Y_W  window row end (inclusive)
color  in  16  RGB565 fill value
busy  out  1  high from the cycle after an accepted start until done/error
done  out  1  one-cycle pulse on completion
error  out  1  one-cycle pulse on rejected window
bus_data  out  16  word to bus controller data_input
bus_cmd  out  1  to bus controller data_command; 0 = index (RS low), 1 = data
bus_step  out  1  to bus controller transfer_step; one-cycle high pulse per word
bus_busy  in  1  bus controller busy; extends gap while high

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, error=0, bus_step=0, bus_cmd=1, bus_data=16'h0000, all counters 0. Reset mid-operation aborts immediately; no further words after release.
- All outputs are registered.
- IDLE with start=1: latch x0, x1, y0, y1, color.
  - Reject if x1<x0, y1<y0, x1>=H_RES or y1>=V_RES. On reject: error pulse next cycle, busy stays 0, no step, return to IDLE.
  - Otherwise busy=1 next cycle, with the first step in that same cycle.
- Start is ignored while busy=1. Latched values are unaffected by input changes during an operation.
- Word issue (ISSUE state): bus_data/bus_cmd are set and bus_step=1 for exactly one cycle.
- WAIT state: bus_data/bus_cmd are held stable and bus_step=0 for STEP_GAP cycles. After that, remain in WAIT while bus_busy=1, then advance. Hold stability is required because the controller samples data/command in the cycle after it detects the edge.
- Word order:
  - Indices and their data words, each data word being {8'h00, byte}: 0x0002 then x0[15:8]; 0x0003 then x0[7:0]; 0x0004 then x1[15:8]; 0x0005 then x1[7:0]; 0x0006 then y0[15:8]; 0x0007 then y0[7:0]; 0x0008 then y1[15:8]; 0x0009 then y1[7:0]. Coordinates are zero-extended to 16 bits.
  - Index 0x0022 (GRAM write).
  - Then N=(x1-x0+1)*(y1-y0+1) data words = color.
- Pixel counting uses nested column and row counters (col runs x0..x1; on wrap col returns to x0 and row increments; the last pixel is col=x1, row=y1). No multiplier.
- States: IDLE, ISSUE, WAIT, DONE. A sub-phase register selects REG (word index 0..15), GRAM_IDX, or PIXEL.
- Total words = 17+N. Minimum cycles from the first step to done = (17+N)*(1+STEP_GAP).
- After the last word's WAIT completes: DONE for one cycle, with done=1 and busy=0 in that same cycle, then IDLE. bus_cmd returns to 1 in IDLE; bus_data holds its last value.
- Single-pixel window (x0=x1, y0=y1) is legal: N=1.

Test Plan:
- Window (10,20)-(11,21), color 16'hF800, bus_busy=0, STEP_GAP=4:
  - Required steps: 0x0002/0x0000, 0x0003/0x000A, 0x0004/0x0000, 0x0005/0x000B, 0x0006/0x0000, 0x0007/0x0014, 0x0008/0x0000, 0x0009/0x0015, 0x0022 with cmd=0, then 4× 0xF800 with cmd=1.
  - Steps exactly 5 cycles apart; done 105 cycles after the first step.
- Single pixel (0,0)-(0,0), color 16'h001F -> 18 steps, last data 0x001F, one done pulse.
- Window (239,399)-(239,399) accepted (x data 0x00EF, y hi/lo 0x0001/0x008F). Each of the following -> one error pulse, zero steps, busy never 1:
  - x1=240
  - x0=5, x1=4
  - y0=5, y1=4
- bus_busy held high 10 cycles after the third step -> next step delayed until bus_busy falls, data/cmd stable throughout, word sequence unchanged.
- start pulsed again mid-pixel phase with different window -> ignored; sequence and N match the first request.
- rst=0 during pixel 2 of a 4-pixel fill -> outputs at reset values immediately, no steps until a new start. A new start after release produces the full sequence from index 0x0002.
